// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts one byte plus odd parity out on device-generated clock edges.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 5000,
    parameter int START_SETUP_CYCLES = 50,
    parameter int TIMEOUT_CYCLES     = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       send_valid,
    input  logic [7:0] send_data,
    output logic       ready,
    output logic       ps2c_drive_low,
    output logic       ps2d_drive_low,
    output logic       done,
    output logic       ack_error,
    output logic       timeout_error
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_SETUP_CYCLES) ? INHIBIT_CYCLES
                                                                     : START_SETUP_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PHASE_W-1:0]   INHIBIT_LAST = PHASE_W'(INHIBIT_CYCLES - 1);
    localparam logic [PHASE_W-1:0]   SETUP_LAST   = PHASE_W'(START_SETUP_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE
    } stateT;

    stateT                state;
    logic [PHASE_W-1:0]   phaseCnt;
    logic [TIMEOUT_W-1:0] timeoutCnt;
    logic [3:0]           bitCnt;
    logic [7:0]           dataReg;
    logic                 parityBit;
    logic                 ackReg;

    logic ps2cMeta, ps2cSync, ps2cPrev;
    logic ps2dMeta, ps2dSync;

    logic       fallEdge;
    logic [3:0] nextBit;

    assign fallEdge = ps2cPrev & ~ps2cSync;
    assign nextBit  = bitCnt + 4'd1;

    // NOTE: every register here is sequential state, so all updates use <=;
    // reset has priority and returns the lines to the released (idle-high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2cMeta       <= 1'b1;
            ps2cSync       <= 1'b1;
            ps2cPrev       <= 1'b1;
            ps2dMeta       <= 1'b1;
            ps2dSync       <= 1'b1;
            state          <= IDLE;
            phaseCnt       <= '0;
            timeoutCnt     <= '0;
            bitCnt         <= '0;
            dataReg        <= '0;
            parityBit      <= 1'b0;
            ackReg         <= 1'b0;
            ready          <= 1'b1;
            ps2c_drive_low <= 1'b0;
            ps2d_drive_low <= 1'b0;
            done           <= 1'b0;
            ack_error      <= 1'b0;
            timeout_error  <= 1'b0;
        end else begin
            ps2cMeta <= ps2c;
            ps2cSync <= ps2cMeta;
            ps2cPrev <= ps2cSync;
            ps2dMeta <= ps2d;
            ps2dSync <= ps2dMeta;

            done          <= 1'b0;
            ack_error     <= 1'b0;
            timeout_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (send_valid) begin
                        dataReg        <= send_data;
                        parityBit      <= ~^send_data;
                        ready          <= 1'b0;
                        ps2c_drive_low <= 1'b1;
                        ps2d_drive_low <= 1'b0;
                        phaseCnt       <= '0;
                        state          <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (phaseCnt == INHIBIT_LAST) begin
                        phaseCnt       <= '0;
                        ps2d_drive_low <= 1'b1;
                        state          <= REQ;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end

                REQ: begin
                    if (phaseCnt == SETUP_LAST) begin
                        phaseCnt       <= '0;
                        ps2c_drive_low <= 1'b0;
                        bitCnt         <= '0;
                        timeoutCnt     <= '0;
                        state          <= SHIFT;
                    end else begin
                        phaseCnt <= phaseCnt + 1'b1;
                    end
                end

                SHIFT, WAIT_IDLE: begin
                    // Timeout wins over any edge or idle condition seen this cycle.
                    if (timeoutCnt == TIMEOUT_LAST) begin
                        ps2c_drive_low <= 1'b0;
                        ps2d_drive_low <= 1'b0;
                        done           <= 1'b1;
                        timeout_error  <= 1'b1;
                        ready          <= 1'b1;
                        state          <= IDLE;
                    end else begin
                        timeoutCnt <= timeoutCnt + 1'b1;
                        if (state == SHIFT) begin
                            if (fallEdge) begin
                                bitCnt <= nextBit;
                                case (nextBit)
                                    4'd1, 4'd2, 4'd3, 4'd4,
                                    4'd5, 4'd6, 4'd7, 4'd8: ps2d_drive_low <= ~dataReg[bitCnt[2:0]];
                                    4'd9:    ps2d_drive_low <= ~parityBit;
                                    4'd10:   ps2d_drive_low <= 1'b0;
                                    4'd11: begin
                                        ackReg <= ~ps2dSync;
                                        state  <= WAIT_IDLE;
                                    end
                                    default: ps2d_drive_low <= ps2d_drive_low;
                                endcase
                            end
                        end else if (ps2cSync && ps2dSync) begin
                            done      <= 1'b1;
                            ack_error <= ~ackReg;
                            ready     <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model
// that clocks the frame, samples data on rising edges and optionally acks.
module tb_ps2_host_tx;

    localparam int INH   = 20;
    localparam int SETUP = 4;
    localparam int TO    = 2000;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       reset;
    logic       send_valid;
    logic [7:0] send_data;
    logic       ready, ps2c_drive_low, ps2d_drive_low, done, ack_error, timeout_error;

    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;
    logic ps2cLine, ps2dLine;

    assign ps2cLine = ~(ps2c_drive_low | devClkLow);
    assign ps2dLine = ~(ps2d_drive_low | devDataLow);

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .START_SETUP_CYCLES(SETUP),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ps2c          (ps2cLine),
        .ps2d          (ps2dLine),
        .send_valid    (send_valid),
        .send_data     (send_data),
        .ready         (ready),
        .ps2c_drive_low(ps2c_drive_low),
        .ps2d_drive_low(ps2d_drive_low),
        .done          (done),
        .ack_error     (ack_error),
        .timeout_error (timeout_error)
    );

    always #5 clk = ~clk;

    int   assertCount = 0;
    int   failCount   = 0;
    int   doneCount   = 0;
    logic lastAckErr, lastToErr, lastReady, lastDlow;

    // Records every done pulse shortly after the edge that produced it.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            doneCount++;
            lastAckErr = ack_error;
            lastToErr  = timeout_error;
            lastReady  = ready;
            lastDlow   = ps2d_drive_low;
        end
    end

    task automatic startSend(input logic [7:0] d, input bit inject,
                             output int inhCnt, output int reqCnt);
        @(negedge clk);
        send_valid = 1'b1;
        send_data  = d;
        @(negedge clk);
        send_valid = 1'b0;
        send_data  = 8'h00;
        inhCnt = 0;
        while (ps2c_drive_low && !ps2d_drive_low && inhCnt < 200) begin
            inhCnt++;
            if (inject && inhCnt == 5) begin
                send_valid = 1'b1;
                send_data  = 8'h12;
            end else begin
                send_valid = 1'b0;
            end
            @(negedge clk);
        end
        send_valid = 1'b0;
        reqCnt = 0;
        while (ps2c_drive_low && ps2d_drive_low && reqCnt < 200) begin
            reqCnt++;
            @(negedge clk);
        end
    endtask

    task automatic devClock(input int nPulses, input bit giveAck, output logic [10:0] frame);
        frame = 11'h7FF;
        repeat (10) @(negedge clk);
        frame[0] = ps2dLine;
        for (int k = 1; k <= nPulses; k++) begin
            devClkLow = 1'b1;
            repeat (HALF) @(negedge clk);
            devClkLow = 1'b0;
            if (k <= 10) frame[k] = ps2dLine;
            if (k == 10 && giveAck) devDataLow = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        devDataLow = 1'b0;
    endtask

    task automatic waitDone(input int prev, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (doneCount > prev) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        send_valid = 1'b0;
        send_data  = 8'h00;
        repeat (3) @(negedge clk);
        assertCount++;
        if ({ready, ps2c_drive_low, ps2d_drive_low, done, ack_error, timeout_error} !== 6'b100000) begin
            failCount++;
            $display("FAIL reset_outputs: got %b expected 100000",
                     {ready, ps2c_drive_low, ps2d_drive_low, done, ack_error, timeout_error});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        assertCount++;
        if ({ready, ps2c_drive_low, ps2d_drive_low, done} !== 4'b1000) begin
            failCount++;
            $display("FAIL post_reset_idle: got %b expected 1000",
                     {ready, ps2c_drive_low, ps2d_drive_low, done});
        end
    endtask

    task automatic test_send_ed();
        int         inhCnt, reqCnt, prev;
        logic [10:0] frame;
        bit         seen;
        assertCount++;
        if (ready !== 1'b1) begin
            failCount++;
            $display("FAIL ed_ready_before: got %b expected 1", ready);
        end
        prev = doneCount;
        startSend(8'hED, 1'b0, inhCnt, reqCnt);
        assertCount++;
        if (inhCnt !== INH) begin
            failCount++;
            $display("FAIL ed_inhibit_len: got %0d expected %0d", inhCnt, INH);
        end
        assertCount++;
        if (reqCnt !== SETUP) begin
            failCount++;
            $display("FAIL ed_req_len: got %0d expected %0d", reqCnt, SETUP);
        end
        devClock(11, 1'b1, frame);
        waitDone(prev, seen);
        assertCount++;
        if (frame !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
            failCount++;
            $display("FAIL ed_frame: got %b expected %b", frame, {1'b1, 1'b1, 8'hED, 1'b0});
        end
        assertCount++;
        if (!seen || {lastAckErr, lastToErr, lastReady, lastDlow} !== 4'b0010) begin
            failCount++;
            $display("FAIL ed_done_status: seen %b ack/to/ready/dlow %b expected 0010",
                     seen, {lastAckErr, lastToErr, lastReady, lastDlow});
        end
    endtask

    task automatic test_parity();
        logic [7:0]  bytes [2] = '{8'h01, 8'hFF};
        logic [10:0] exp   [2] = '{{1'b1, 1'b0, 8'h01, 1'b0}, {1'b1, 1'b1, 8'hFF, 1'b0}};
        for (int v = 0; v < 2; v++) begin
            int         inhCnt, reqCnt, prev;
            logic [10:0] frame;
            bit         seen;
            prev = doneCount;
            startSend(bytes[v], 1'b0, inhCnt, reqCnt);
            devClock(11, 1'b1, frame);
            waitDone(prev, seen);
            assertCount++;
            if (frame !== exp[v]) begin
                failCount++;
                $display("FAIL parity_frame_%0h: got %b expected %b", bytes[v], frame, exp[v]);
            end
            assertCount++;
            if (!seen || {lastAckErr, lastToErr} !== 2'b00) begin
                failCount++;
                $display("FAIL parity_done_%0h: seen %b ack/to %b expected 00",
                         bytes[v], seen, {lastAckErr, lastToErr});
            end
        end
    endtask

    task automatic test_no_ack();
        int         inhCnt, reqCnt, prev;
        logic [10:0] frame;
        bit         seen;
        prev = doneCount;
        startSend(8'hF3, 1'b0, inhCnt, reqCnt);
        devClock(11, 1'b0, frame);
        waitDone(prev, seen);
        assertCount++;
        if (!seen || {lastAckErr, lastToErr, lastReady} !== 3'b101) begin
            failCount++;
            $display("FAIL no_ack_status: seen %b ack/to/ready %b expected 101",
                     seen, {lastAckErr, lastToErr, lastReady});
        end
    endtask

    task automatic test_timeout();
        int inhCnt, reqCnt, prev, cnt;
        prev = doneCount;
        startSend(8'hEE, 1'b0, inhCnt, reqCnt);
        cnt = 0;
        while (doneCount == prev && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        assertCount++;
        if (cnt !== TO) begin
            failCount++;
            $display("FAIL timeout_latency: got %0d cycles expected %0d", cnt, TO);
        end
        assertCount++;
        if ({lastToErr, lastAckErr, lastReady, ps2c_drive_low, ps2d_drive_low} !== 5'b10100) begin
            failCount++;
            $display("FAIL timeout_status: to/ack/ready/clow/dlow %b expected 10100",
                     {lastToErr, lastAckErr, lastReady, ps2c_drive_low, ps2d_drive_low});
        end
    endtask

    task automatic test_reset_mid_transfer();
        int         inhCnt, reqCnt, prev;
        logic [10:0] frame;
        bit         seen;
        prev = doneCount;
        startSend(8'hAA, 1'b0, inhCnt, reqCnt);
        devClock(5, 1'b0, frame);
        assertCount++;
        if (ps2d_drive_low !== 1'b1) begin
            failCount++;
            $display("FAIL aa_bit5_drive: got %b expected 1", ps2d_drive_low);
        end
        reset = 1'b1;
        @(negedge clk);
        assertCount++;
        if ({ps2c_drive_low, ps2d_drive_low, ready} !== 3'b001) begin
            failCount++;
            $display("FAIL reset_mid_release: clow/dlow/ready %b expected 001",
                     {ps2c_drive_low, ps2d_drive_low, ready});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        assertCount++;
        if (doneCount !== prev) begin
            failCount++;
            $display("FAIL reset_no_done: got %0d pulses expected 0", doneCount - prev);
        end
        prev = doneCount;
        startSend(8'h55, 1'b0, inhCnt, reqCnt);
        devClock(11, 1'b1, frame);
        waitDone(prev, seen);
        assertCount++;
        if (frame !== {1'b1, 1'b1, 8'h55, 1'b0} || !seen || {lastAckErr, lastToErr} !== 2'b00) begin
            failCount++;
            $display("FAIL after_reset_55: frame %b seen %b ack/to %b expected %b 1 00",
                     frame, seen, {lastAckErr, lastToErr}, {1'b1, 1'b1, 8'h55, 1'b0});
        end
    endtask

    task automatic test_back_to_back();
        int         inhCnt, reqCnt, prev;
        logic [10:0] frame;
        bit         seen;
        prev = doneCount;
        startSend(8'hF4, 1'b1, inhCnt, reqCnt);
        devClock(11, 1'b1, frame);
        waitDone(prev, seen);
        repeat (200) @(negedge clk);
        assertCount++;
        if (frame !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
            failCount++;
            $display("FAIL ignored_req_frame: got %b expected %b", frame, {1'b1, 1'b0, 8'hF4, 1'b0});
        end
        assertCount++;
        if (doneCount - prev !== 1 || {ps2c_drive_low, ready} !== 2'b01) begin
            failCount++;
            $display("FAIL ignored_req_done: pulses %0d clow/ready %b expected 1 01",
                     doneCount - prev, {ps2c_drive_low, ready});
        end
    endtask

    initial begin
        test_reset();
        test_send_ed();
        test_parity();
        test_no_ack();
        test_timeout();
        test_reset_mid_transfer();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
